// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding, requester count
// and the op code values understood by the parent-level ALU.
package alu_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // The arbiter never decodes these; they document what the shared ALU implements.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_LUI = 4'b1001;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational grant selection between the two requesters, one-hot result.
// ALU_ARB_FIXED_PRIO_EN makes requester 0 always win and removes the pointer input.
module alu_arb_pick
    import alu_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic               last_served,
`endif
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = valid;
        // Contention: the requester that was not served last takes the slot.
        if (valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 2'b01;
`else
            grant = last_served ? 2'b01 : 2'b10;
`endif
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU instantiated by the parent.
// Round-robin by default; define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid_i,
    input  logic [OP_W-1:0]   req0_op_i,
    input  logic [DATA_W-1:0] req0_a_i,
    input  logic [DATA_W-1:0] req0_b_i,
    output logic              req0_ready_o,

    input  logic              req1_valid_i,
    input  logic [OP_W-1:0]   req1_op_i,
    input  logic [DATA_W-1:0] req1_a_i,
    input  logic [DATA_W-1:0] req1_b_i,
    output logic              req1_ready_o,

    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_result_o,
    output logic              rsp0_zero_o,
    input  logic              rsp0_ready_i,

    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_result_o,
    output logic              rsp1_zero_o,
    input  logic              rsp1_ready_i,

    output logic [OP_W-1:0]   alu_op_o,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i
);

    arb_state_t         state_q;
    arb_state_t         state_d;
    logic [NUM_REQ-1:0] valid_vec;
    logic [NUM_REQ-1:0] rsp_ready_vec;
    logic [NUM_REQ-1:0] pick_grant;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               accept;

    logic [OP_W-1:0]    sel_op;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  result_q;
    logic               zero_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic               last_q;
`endif

    assign valid_vec     = {req1_valid_i, req0_valid_i};
    assign rsp_ready_vec = {rsp1_ready_i, rsp0_ready_i};

    alu_arb_pick u_pick (
        .valid       (valid_vec),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .last_served (last_q),
`endif
        .grant       (pick_grant)
    );

    assign sel_op = pick_grant[1] ? req1_op_i : req0_op_i;
    assign sel_a  = pick_grant[1] ? req1_a_i  : req0_a_i;
    assign sel_b  = pick_grant[1] ? req1_b_i  : req0_b_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = pick_grant;
                if (|pick_grant) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = grant_q;
                if (|(grant_q & rsp_ready_vec)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The ALU is driven straight from these registers so its inputs never glitch with requester traffic.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            grant_q <= '0;
        end else if (accept) begin
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            grant_q <= pick_grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_q <= alu_result_i;
            zero_q   <= alu_zero_i;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Reset to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= pick_grant[1];
        end
    end
`endif

    assign req0_ready_o  = req_ready[0];
    assign req1_ready_o  = req_ready[1];
    assign rsp0_valid_o  = rsp_valid[0];
    assign rsp1_valid_o  = rsp_valid[1];
    assign rsp0_result_o = result_q;
    assign rsp1_result_o = result_q;
    assign rsp0_zero_o   = zero_q;
    assign rsp1_zero_o   = zero_q;
    assign alu_op_o      = op_q;
    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: requester queues feed a transaction-level arbiter
// model that pushes expected responses; a separate monitor pops them as the DUT responds.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    typedef struct {
        int                id;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] result;
        logic              zero;
        int                acc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid_i, req1_valid_i;
    logic [OP_W-1:0]   req0_op_i, req1_op_i;
    logic [DATA_W-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
    logic              req0_ready_o, req1_ready_o;
    logic              rsp0_valid_o, rsp1_valid_o;
    logic [DATA_W-1:0] rsp0_result_o, rsp1_result_o;
    logic              rsp0_zero_o, rsp1_zero_o;
    logic              rsp0_ready_i, rsp1_ready_i;
    logic [OP_W-1:0]   alu_op_o;
    logic [DATA_W-1:0] alu_a_o, alu_b_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_zero_i;

    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    bit   rnd_mode = 1'b0;
    bit [1:0] rsp_force = 2'b11;

    req_t pend0[$];
    req_t pend1[$];
    exp_t sb[$];

    bit   model_busy = 1'b0;
    int   model_last = 1;
    int   cur_id = 0;
    int   cur_acc = 0;

    alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(req0_valid_i), .req0_op_i(req0_op_i), .req0_a_i(req0_a_i),
        .req0_b_i(req0_b_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_op_i(req1_op_i), .req1_a_i(req1_a_i),
        .req1_b_i(req1_b_i), .req1_ready_o(req1_ready_o),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_result_o(rsp0_result_o),
        .rsp0_zero_o(rsp0_zero_o), .rsp0_ready_i(rsp0_ready_i),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_result_o(rsp1_result_o),
        .rsp1_zero_o(rsp1_zero_o), .rsp1_ready_i(rsp1_ready_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Parent-level ALU: unknown op codes return 0.
    function automatic logic [DATA_W-1:0] alu_model(input logic [OP_W-1:0] op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_XOR:  return a ^ b;
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_LUI:  return b << 12;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        alu_result_i = alu_model(alu_op_o, alu_a_o, alu_b_o);
        alu_zero_i   = (alu_result_i == '0);
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic apply_stimulus(input int id, input logic [OP_W-1:0] op,
                                  input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req_t r;
        r.op = op;
        r.a  = a;
        r.b  = b;
        if (id == 0) pend0.push_back(r);
        else         pend1.push_back(r);
    endtask

    // Requesters: hold valid/payload until ready was seen, then present the next queued op.
    initial begin : req_driver
        bit   took0, took1;
        req_t r;
        req0_valid_i = 1'b0; req0_op_i = '0; req0_a_i = '0; req0_b_i = '0;
        req1_valid_i = 1'b0; req1_op_i = '0; req1_a_i = '0; req1_b_i = '0;
        forever begin
            @(negedge clk);
            took0 = req0_ready_o;
            took1 = req1_ready_o;
            @(posedge clk);
            #1;
            if (took0) req0_valid_i = 1'b0;
            if (took1) req1_valid_i = 1'b0;
            if (!req0_valid_i && pend0.size() > 0 && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
                r = pend0.pop_front();
                req0_valid_i = 1'b1; req0_op_i = r.op; req0_a_i = r.a; req0_b_i = r.b;
            end
            if (!req1_valid_i && pend1.size() > 0 && (!rnd_mode || $urandom_range(0, 2) != 0)) begin
                r = pend1.pop_front();
                req1_valid_i = 1'b1; req1_op_i = r.op; req1_a_i = r.a; req1_b_i = r.b;
            end
        end
    end

    initial begin : rsp_driver
        rsp0_ready_i = 1'b1;
        rsp1_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                rsp0_ready_i = 1'($urandom_range(0, 1));
                rsp1_ready_i = 1'($urandom_range(0, 1));
            end else begin
                rsp0_ready_i = rsp_force[0];
                rsp1_ready_i = rsp_force[1];
            end
        end
    end

    // Transaction model: one op in flight; accepted ops are pushed with their expected response.
    always @(negedge clk) begin : accept_model
        logic [1:0] exp_rdy;
        int   w;
        exp_t e;
        if (!reset) begin
            model_busy = 1'b0;
            model_last = 1;
            sb.delete();
        end else if (!model_busy) begin
            exp_rdy = 2'b00;
            if (req0_valid_i || req1_valid_i) begin
                if (req0_valid_i && req1_valid_i) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    w = 0;
`else
                    w = (model_last == 0) ? 1 : 0;
`endif
                end else begin
                    w = req1_valid_i ? 1 : 0;
                end
                exp_rdy  = (w == 1) ? 2'b10 : 2'b01;
                e.id     = w;
                e.op     = (w == 1) ? req1_op_i : req0_op_i;
                e.a      = (w == 1) ? req1_a_i  : req0_a_i;
                e.b      = (w == 1) ? req1_b_i  : req0_b_i;
                e.result = alu_model(e.op, e.a, e.b);
                e.zero   = (e.result == '0);
                e.acc    = cycle;
                sb.push_back(e);
                model_busy = 1'b1;
                model_last = w;
                cur_id     = w;
                cur_acc    = cycle;
            end
            check_output("req_ready_idle", 64'({req1_ready_o, req0_ready_o}), 64'(exp_rdy));
        end else begin
            check_output("req_ready_busy", 64'({req1_ready_o, req0_ready_o}), 64'(0));
            if (cycle >= cur_acc + 2 && ((cur_id == 1) ? rsp1_ready_i : rsp0_ready_i))
                model_busy = 1'b0;
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    always @(negedge clk) begin : rsp_monitor
        logic [1:0] exp_v;
        exp_t e;
        if (reset) begin
            exp_v = 2'b00;
            if (sb.size() > 0) begin
                e = sb[0];
                if (cycle == e.acc + 1) begin
                    check_output("alu_op_exec", 64'(alu_op_o), 64'(e.op));
                    check_output("alu_a_exec",  64'(alu_a_o),  64'(e.a));
                    check_output("alu_b_exec",  64'(alu_b_o),  64'(e.b));
                end
                if (cycle >= e.acc + 2) exp_v = (e.id == 1) ? 2'b10 : 2'b01;
            end
            check_output("rsp_valid", 64'({rsp1_valid_o, rsp0_valid_o}), 64'(exp_v));
            if (exp_v != 2'b00) begin
                check_output("rsp_result", 64'((e.id == 1) ? rsp1_result_o : rsp0_result_o), 64'(e.result));
                check_output("rsp_zero",   64'((e.id == 1) ? rsp1_zero_o   : rsp0_zero_o),   64'(e.zero));
                if ((e.id == 1) ? rsp1_ready_i : rsp0_ready_i) void'(sb.pop_front());
            end
        end
    end

    task automatic check_reset_values();
        check_output("rst_req_ready", 64'({req1_ready_o, req0_ready_o}), 64'(0));
        check_output("rst_rsp_valid", 64'({rsp1_valid_o, rsp0_valid_o}), 64'(0));
        check_output("rst_result0",   64'(rsp0_result_o), 64'(0));
        check_output("rst_result1",   64'(rsp1_result_o), 64'(0));
        check_output("rst_zero",      64'({rsp1_zero_o, rsp0_zero_o}), 64'(0));
        check_output("rst_alu_op",    64'(alu_op_o), 64'(0));
        check_output("rst_alu_a",     64'(alu_a_o),  64'(0));
        check_output("rst_alu_b",     64'(alu_b_o),  64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || req0_valid_i || req1_valid_i ||
                model_busy || sb.size() > 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) check_output("drain_timeout", 64'(n), 64'(limit - 1));
        @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n;
        logic [DATA_W-1:0] ra;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 reset = 1'b1;

        $display("[TB] single ADD 5+7");
        apply_stimulus(0, OP_ADD, 32'd5, 32'd7);
        wait_idle(50);

        $display("[TB] contention after reset: SUB on req0, LUI on req1, then a second contention");
        do_reset();
        apply_stimulus(0, OP_SUB, 32'd9, 32'd9);
        apply_stimulus(1, OP_LUI, 32'd0, 32'd1);
        wait_idle(50);
        apply_stimulus(0, OP_XOR, 32'h0000_00ff, 32'h0000_0f0f);
        apply_stimulus(1, OP_OR,  32'h1234_0000, 32'h0000_5678);
        wait_idle(50);

        $display("[TB] response back-pressure on req1");
        rsp_force = 2'b01;
        apply_stimulus(1, OP_AND, 32'h0000_f0f0, 32'h0000_0ff0);
        n = 0;
        while (!rsp1_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_output("rsp1_wait_timeout", 64'(n), 64'(0));
        repeat (4) @(negedge clk);
        rsp_force = 2'b11;
        wait_idle(50);

        $display("[TB] reset during EXEC drops the operation");
        apply_stimulus(0, OP_ADD, 32'd1, 32'd2);
        n = 0;
        while (!req0_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_output("accept_wait_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);

        $display("[TB] undefined op code 4'b1111");
        apply_stimulus(0, 4'b1111, 32'd3, 32'd4);
        wait_idle(50);

        $display("[TB] sustained contention, three ops per requester");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, OP_SLL, 32'd1, 32'(i + 1));
            apply_stimulus(1, OP_SRL, 32'h8000_0000, 32'(i + 4));
        end
        wait_idle(100);

        $display("[TB] randomized traffic");
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            apply_stimulus(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra,
                           ($urandom_range(0, 3) == 0) ? ra : DATA_W'($urandom));
        end
        wait_idle(2000);
        rnd_mode = 1'b0;
        repeat (3) @(negedge clk);

        check_output("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width.
REQ-002 Parameter OP_W, default 4, ALU operation code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 reqN_valid_i  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_op_i  input  OP_W  requester N operation code.
REQ-007 reqN_a_i / reqN_b_i  input  DATA_W each  requester N operands A, B.
REQ-008 reqN_ready_o  output  1  arbiter accepts requester N operation this cycle.
REQ-009 rspN_valid_o  output  1  result for requester N available.
REQ-010 rspN_result_o  output  DATA_W  result for requester N.
REQ-011 rspN_zero_o  output  1  zero flag for requester N.
REQ-012 rspN_ready_i  input  1  requester N consumes response.
REQ-013 alu_op_o / alu_a_o / alu_b_o  output  OP_W / DATA_W / DATA_W  drive to the shared ALU.
REQ-014 alu_result_i / alu_zero_i  input  DATA_W / 1  combinational return from the shared ALU.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-016 IDLE: if any reqN_valid_i, grant one requester, assert its reqN_ready_o combinationally the same cycle, capture op/A/B into registers, grant into grant register, go EXEC.
REQ-017 IDLE with no valid: stay IDLE, both reqN_ready_o low.
REQ-018 reqN_ready_o SHALL be high only in IDLE and only for the granted requester; never both.
REQ-019 Requester SHALL hold valid and payload stable until ready; arbiter relies on this.
REQ-020 Round-robin: single valid wins; both valid -> requester not served last wins; last-served pointer updates on accept.
REQ-021 alu_op_o/alu_a_o/alu_b_o SHALL come directly from capture registers in every state.
REQ-022 EXEC: register alu_result_i and alu_zero_i at end of cycle, go RESP; EXEC lasts exactly one cycle.
REQ-023 RESP: rspG_valid_o high for granted requester G only, result/zero stable until rspG_ready_i; on handshake go IDLE.
REQ-024 Latency: accept at cycle T -> rsp valid at T+2; minimum issue interval 3 cycles.
REQ-025 Undefined op codes SHALL be forwarded unchanged; arbiter performs no op decoding.
REQ-026 Non-granted rspN_valid_o SHALL be low; rspN_result_o/rspN_zero_o SHALL be the shared result registers.

Reset
REQ-027 Assertion at any time, including EXEC/RESP, SHALL force IDLE, discard in-flight operation.
REQ-028 Reset values: all ready/valid outputs 0, result registers 0, zero register 0, op/A/B registers 0, last-served pointer = 1 (requester 0 wins first contention).

Configuration
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win contention; pointer unused.
REQ-030 Macro undefined: round-robin per REQ-020.

Structure
REQ-031 Shared package SHALL hold FSM state encoding and ALU op code constants (ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0111, LUI 1001).
REQ-032 Grant selection SHALL be a combinational sub-module alu_arb_pick (valids, pointer -> one-hot grant).
REQ-033 Shared ALU SHALL be instantiated outside this block at the parent level.

Verification
REQ-034 req0 ADD A=5 B=7 accepted cycle T -> rsp0_valid_o at T+2, result 12, zero 0.
REQ-035 After reset both valid: req0 SUB 9-9, req1 LUI B=1 -> req0 first (result 0, zero 1), then req1 result 0x00001000; round-robin build: next contention goes to req0.
REQ-036 rsp1_ready_i low 4 cycles in RESP -> rsp1_valid_o held, result stable, both reqN_ready_o low throughout.
REQ-037 reset low during EXEC -> next cycle all outputs 0, state IDLE, no response ever issued for dropped op.
REQ-038 ALU_ARB_FIXED_PRIO_EN defined, both valid continuously for 3 operations -> all grants to req0, req1 never ready.
REQ-039 Op 4'b1111 with A=3 B=4, ALU returns 0 -> alu_op_o shows 1111 during EXEC, rsp result 0, zero 1.
